// File: rtl/gray_pkg.sv
// Shared encodings and Gray/binary conversion helpers for the Gray step sequencer.
// Helpers work on a MAX_W-bit container; callers zero-extend narrower values and truncate results.
package gray_pkg;

  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'd0,
    OP_RUN_UP = 2'd1,
    OP_RUN_DN = 2'd2,
    OP_NOP    = 2'd3
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended upper bits leave the prefix XOR unaffected, so any width <= MAX_W converts correctly.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_core.sv
// W-bit counter kept in binary, with registered Gray and binary views of the same count.
module gray_core
  import gray_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         dir,
  output logic [W-1:0] gray_out,
  output logic [W-1:0] bin_out
);

  logic [W-1:0] bin_next;

  // dir = 1 counts down; arithmetic wraps naturally modulo 2^W.
  always_comb begin
    bin_next = bin_out;
    if (load) begin
      bin_next = load_val;
    end else if (en) begin
      bin_next = dir ? (bin_out - W'(1)) : (bin_out + W'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_out  <= '0;
      gray_out <= '0;
    end else begin
      bin_out  <= bin_next;
      gray_out <= W'(bin2gray(MAX_W'(bin_next)));
    end
  end

endmodule

// File: rtl/gray_step_ctrl.sv
// Command sequencer: accepts LOAD / RUN_UP / RUN_DN over valid/ready and steps the Gray core once per clock.
module gray_step_ctrl
  import gray_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [W-1:0] cmd_arg,
  input  logic         abort,
  output logic [W-1:0] gray_out,
  output logic [W-1:0] bin_out,
  output logic         busy,
  output logic         done,
  output logic         aborted
);

  state_e       state;
  logic [W-1:0] remaining;
  logic         dir_q;
  logic         core_load;
  logic         core_en;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state == ST_RUN);
  assign core_load = cmd_ready && cmd_valid && (cmd_op == OP_LOAD);
  assign core_en   = busy && !abort;

  gray_core #(.W(W)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (core_load),
    .load_val (cmd_arg),
    .en       (core_en),
    .dir      (dir_q),
    .gray_out (gray_out),
    .bin_out  (bin_out)
  );

  // Abort takes priority over the final step so an aborted run never reports done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      remaining <= '0;
      dir_q     <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (op_e'(cmd_op))
              OP_RUN_UP, OP_RUN_DN: begin
                if (cmd_arg == '0) begin
                  done <= 1'b1;
                end else begin
                  remaining <= cmd_arg;
                  dir_q     <= (cmd_op == OP_RUN_DN);
                  state     <= ST_RUN;
                end
              end
              default: done <= 1'b1;
            endcase
          end
        end
        ST_RUN: begin
          if (abort) begin
            state     <= ST_IDLE;
            aborted   <= 1'b1;
            remaining <= '0;
          end else begin
            remaining <= remaining - W'(1);
            if (remaining == W'(1)) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_step_ctrl.sv
// Directed self-checking bench for gray_step_ctrl at W = 4 with hand-computed Gray/binary values.
module tb_gray_step_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_arg;
  logic       abort;
  logic [3:0] gray_out;
  logic [3:0] bin_out;
  logic       busy;
  logic       done;
  logic       aborted;

  int cmp_count  = 0;
  int fail_count = 0;

  gray_step_ctrl #(.W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .abort     (abort),
    .gray_out  (gray_out),
    .bin_out   (bin_out),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for cmd_ready, then presents one command for exactly one accept edge.
  task automatic send(input logic [1:0] op, input logic [3:0] arg);
    int waited = 0;
    while (!cmd_ready && waited < 32) begin
      tick();
      waited++;
    end
    cmp_count++;
    if (cmd_ready !== 1'b1) begin
      fail_count++;
      $display("[TB] FAIL send_ready_timeout act=%b exp=1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = 4'd0; abort = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    cmp_count++; if (gray_out !== 4'b0000) begin fail_count++; $display("[TB] FAIL reset_gray act=%b exp=0000", gray_out); end
    cmp_count++; if (bin_out !== 4'b0000) begin fail_count++; $display("[TB] FAIL reset_bin act=%b exp=0000", bin_out); end
    cmp_count++; if (cmd_ready !== 1'b1) begin fail_count++; $display("[TB] FAIL reset_ready act=%b exp=1", cmd_ready); end
    cmp_count++; if (busy !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_busy act=%b exp=0", busy); end
    cmp_count++; if ({done, aborted} !== 2'b00) begin fail_count++; $display("[TB] FAIL reset_pulses act=%b exp=00", {done, aborted}); end
  endtask

  task automatic test_load();
    send(2'd0, 4'd5);
    cmp_count++; if (gray_out !== 4'b0111) begin fail_count++; $display("[TB] FAIL load_gray act=%b exp=0111", gray_out); end
    cmp_count++; if (bin_out !== 4'b0101) begin fail_count++; $display("[TB] FAIL load_bin act=%b exp=0101", bin_out); end
    cmp_count++; if (done !== 1'b1) begin fail_count++; $display("[TB] FAIL load_done act=%b exp=1", done); end
    cmp_count++; if (busy !== 1'b0) begin fail_count++; $display("[TB] FAIL load_busy act=%b exp=0", busy); end
    tick();
    cmp_count++; if (done !== 1'b0) begin fail_count++; $display("[TB] FAIL load_done_width act=%b exp=0", done); end
  endtask

  task automatic test_run_up();
    logic [3:0] exp_g [3] = '{4'b0101, 4'b0100, 4'b1100};
    logic [3:0] exp_b [3] = '{4'd6, 4'd7, 4'd8};
    logic [3:0] prev;
    prev = gray_out;
    send(2'd1, 4'd3);
    cmp_count++; if (gray_out !== 4'b0111) begin fail_count++; $display("[TB] FAIL runup_accept_gray act=%b exp=0111", gray_out); end
    for (int k = 0; k < 3; k++) begin
      cmp_count++; if (busy !== 1'b1) begin fail_count++; $display("[TB] FAIL runup_busy[%0d] act=%b exp=1", k, busy); end
      cmp_count++; if (cmd_ready !== 1'b0) begin fail_count++; $display("[TB] FAIL runup_ready[%0d] act=%b exp=0", k, cmd_ready); end
      tick();
      cmp_count++; if (gray_out !== exp_g[k]) begin fail_count++; $display("[TB] FAIL runup_gray[%0d] act=%b exp=%b", k, gray_out, exp_g[k]); end
      cmp_count++; if (bin_out !== exp_b[k]) begin fail_count++; $display("[TB] FAIL runup_bin[%0d] act=%b exp=%b", k, bin_out, exp_b[k]); end
      cmp_count++; if (done !== (k == 2)) begin fail_count++; $display("[TB] FAIL runup_done[%0d] act=%b exp=%b", k, done, (k == 2)); end
      cmp_count++; if ($countones(gray_out ^ prev) != 1) begin fail_count++; $display("[TB] FAIL runup_onebit[%0d] act=%b prev=%b", k, gray_out, prev); end
      prev = gray_out;
    end
    cmp_count++; if ({busy, cmd_ready} !== 2'b01) begin fail_count++; $display("[TB] FAIL runup_end_state act=%b exp=01", {busy, cmd_ready}); end
  endtask

  // Covers both wrap directions and a RUN_DN issued in the same cycle that done pulses.
  task automatic test_back_to_back_wrap();
    logic [3:0] exp_g [5] = '{4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b1000};
    logic [3:0] exp_b [5] = '{4'd15, 4'd0, 4'd1, 4'd0, 4'd15};
    logic [3:0] prev;
    send(2'd0, 4'd14);
    cmp_count++; if (gray_out !== 4'b1001) begin fail_count++; $display("[TB] FAIL wrap_load_gray act=%b exp=1001", gray_out); end
    prev = gray_out;
    send(2'd1, 4'd3);
    for (int k = 0; k < 5; k++) begin
      tick();
      cmp_count++; if (gray_out !== exp_g[k]) begin fail_count++; $display("[TB] FAIL wrap_gray[%0d] act=%b exp=%b", k, gray_out, exp_g[k]); end
      cmp_count++; if (bin_out !== exp_b[k]) begin fail_count++; $display("[TB] FAIL wrap_bin[%0d] act=%b exp=%b", k, bin_out, exp_b[k]); end
      cmp_count++; if ($countones(gray_out ^ prev) != 1) begin fail_count++; $display("[TB] FAIL wrap_onebit[%0d] act=%b prev=%b", k, gray_out, prev); end
      prev = gray_out;
      if (k == 2) begin
        cmp_count++; if ({done, cmd_ready} !== 2'b11) begin fail_count++; $display("[TB] FAIL wrap_up_done_ready act=%b exp=11", {done, cmd_ready}); end
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_arg = 4'd2;
        tick();
        cmd_valid = 1'b0;
        cmp_count++; if (busy !== 1'b1) begin fail_count++; $display("[TB] FAIL wrap_dn_busy act=%b exp=1", busy); end
      end
    end
    cmp_count++; if (done !== 1'b1) begin fail_count++; $display("[TB] FAIL wrap_dn_done act=%b exp=1", done); end
  endtask

  task automatic test_abort();
    send(2'd0, 4'd0);
    send(2'd1, 4'd10);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    cmp_count++; if (gray_out !== 4'b0010) begin fail_count++; $display("[TB] FAIL abort_gray act=%b exp=0010", gray_out); end
    cmp_count++; if (bin_out !== 4'b0011) begin fail_count++; $display("[TB] FAIL abort_bin act=%b exp=0011", bin_out); end
    cmp_count++; if ({aborted, done, busy} !== 3'b100) begin fail_count++; $display("[TB] FAIL abort_flags act=%b exp=100", {aborted, done, busy}); end
    abort = 1'b0;
    tick();
    cmp_count++; if (aborted !== 1'b0) begin fail_count++; $display("[TB] FAIL abort_pulse_width act=%b exp=0", aborted); end
    // Abort on the edge that would have been the final step: count must stay at 4.
    send(2'd1, 4'd2);
    tick();
    abort = 1'b1;
    tick();
    cmp_count++; if (gray_out !== 4'b0110) begin fail_count++; $display("[TB] FAIL abort_last_gray act=%b exp=0110", gray_out); end
    cmp_count++; if ({aborted, done} !== 2'b10) begin fail_count++; $display("[TB] FAIL abort_last_flags act=%b exp=10", {aborted, done}); end
    tick();
    cmp_count++; if ({aborted, done, gray_out} !== 6'b00_0110) begin fail_count++; $display("[TB] FAIL abort_idle_ignored act=%b exp=000110", {aborted, done, gray_out}); end
    abort = 1'b0;
  endtask

  task automatic test_zero_and_nop();
    send(2'd1, 4'd0);
    cmp_count++; if ({done, busy, gray_out} !== 6'b10_0110) begin fail_count++; $display("[TB] FAIL zero_run act=%b exp=100110", {done, busy, gray_out}); end
    send(2'd3, 4'd9);
    cmp_count++; if ({done, busy, gray_out} !== 6'b10_0110) begin fail_count++; $display("[TB] FAIL nop_op act=%b exp=100110", {done, busy, gray_out}); end
  endtask

  task automatic test_reset_mid_run();
    send(2'd1, 4'd15);
    repeat (3) tick();
    cmp_count++; if (bin_out !== 4'd7) begin fail_count++; $display("[TB] FAIL midrun_bin act=%0d exp=7", bin_out); end
    #2 rst = 1'b1;
    #1;
    cmp_count++; if ({gray_out, bin_out} !== 8'h00) begin fail_count++; $display("[TB] FAIL midrun_rst_count act=%h exp=00", {gray_out, bin_out}); end
    cmp_count++; if ({busy, cmd_ready, done, aborted} !== 4'b0100) begin fail_count++; $display("[TB] FAIL midrun_rst_flags act=%b exp=0100", {busy, cmd_ready, done, aborted}); end
    tick();
    rst = 1'b0;
    tick();
    cmp_count++; if ({gray_out, done, aborted, busy} !== 7'b0000_000) begin fail_count++; $display("[TB] FAIL midrun_after_rst act=%b exp=0000000", {gray_out, done, aborted, busy}); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_run_up();
    test_back_to_back_wrap();
    test_abort();
    test_zero_and_nop();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog_timeout act=running exp=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
